// File: rtl/output_buffer.sv
// -----------------------------------------------------------------------------
// output_buffer
//
// Registered output side of the memory-mapped IO subsystem. Byte-masked stores
// from the load/store unit land in the LEDR, LEDG, HEXLO, HEXHI and LCD
// registers, and the board pins are driven from those registers. Loads to
// the same addresses read the registers back combinationally.
//
// Optional feature macro: OUTPUT_BUFFER_LCD_SEQ_EN
//   When defined, an LCD strobe sequencer (IDLE/SETUP/PULSE/HOLD) owns the
//   LCD EN pin and generates a timed pulse for every accepted LCD store.
//   LCD stores that arrive while it is busy are dropped and set a sticky
//   overflow flag. When undefined, the LCD register drives the pins directly.
//
// Parameters:
//   BASE_HI    required value of i_addr[31:16] for any register hit
//   SETUP_CYC  LCD EN-low cycles before the pulse (min 1)
//   PULSE_CYC  LCD EN-high cycles (min 1)
//   HOLD_CYC   LCD EN-low cycles after the pulse (min 1)
//
// Ports:
//   i_clk, i_reset       clock (rising edge), async active-high reset
//   i_st_en              store strobe
//   i_addr               store and readback address
//   i_st_data, i_bmask   store data and byte-lane enables
//   o_ld_data            combinational readback of the addressed register
//   o_io_ledr, o_io_ledg red / green LEDs
//   o_io_hex0..7         seven-segment digits
//   o_io_lcd             LCD pins: [31] ON, [10] EN, [9] RS, [8] RW, [7:0] DATA
//   o_lcd_busy           LCD sequencer not idle
// -----------------------------------------------------------------------------
module output_buffer #(
  parameter logic [15:0] BASE_HI   = 16'h1000,
  parameter int          SETUP_CYC = 4,
  parameter int          PULSE_CYC = 25,
  parameter int          HOLD_CYC  = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_st_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  input  logic [3:0]  i_bmask,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd,
  output logic        o_lcd_busy
);

  localparam logic [2:0] SEL_LEDR  = 3'd0;
  localparam logic [2:0] SEL_LEDG  = 3'd1;
  localparam logic [2:0] SEL_HEXLO = 3'd2;
  localparam logic [2:0] SEL_HEXHI = 3'd3;
  localparam logic [2:0] SEL_LCD   = 3'd4;

  logic        hit;
  logic [2:0]  sel;
  logic [31:0] ledr_q, ledg_q, hexlo_q, hexhi_q, lcd_q;
  logic [31:0] store_val;
  logic [31:0] lcd_rd;
  logic        wr_ledr, wr_ledg, wr_hexlo, wr_hexhi, wr_lcd;

  // Bit 15 and the low 12 address bits do not take part in decoding.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[15], i_addr[11:0]};

  assign hit = (i_addr[31:16] == BASE_HI);
  assign sel = i_addr[14:12];

  function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old;
    for (int n = 0; n < 4; n++)
      if (mask[n]) res[8*n +: 8] = data[8*n +: 8];
    return res;
  endfunction

  // The merge source depends on which register is addressed, so the new
  // value is formed once from the selected register's current contents.
  always_comb begin
    store_val = '0;
    case (sel)
      SEL_LEDR:  store_val = merge_lanes(ledr_q,  i_st_data, i_bmask);
      SEL_LEDG:  store_val = merge_lanes(ledg_q,  i_st_data, i_bmask);
      SEL_HEXLO: store_val = merge_lanes(hexlo_q, i_st_data, i_bmask);
      SEL_HEXHI: store_val = merge_lanes(hexhi_q, i_st_data, i_bmask);
      SEL_LCD:   store_val = merge_lanes(lcd_q,   i_st_data, i_bmask);
      default:   store_val = '0;
    endcase
  end

  assign wr_ledr  = i_st_en && hit && (sel == SEL_LEDR);
  assign wr_ledg  = i_st_en && hit && (sel == SEL_LEDG);
  assign wr_hexlo = i_st_en && hit && (sel == SEL_HEXLO);
  assign wr_hexhi = i_st_en && hit && (sel == SEL_HEXHI);
  assign wr_lcd   = i_st_en && hit && (sel == SEL_LCD);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ledr_q  <= '0;
      ledg_q  <= '0;
      hexlo_q <= '0;
      hexhi_q <= '0;
    end else begin
      if (wr_ledr)  ledr_q  <= store_val;
      if (wr_ledg)  ledg_q  <= store_val;
      if (wr_hexlo) hexlo_q <= store_val;
      if (wr_hexhi) hexhi_q <= store_val;
    end
  end

`ifdef OUTPUT_BUFFER_LCD_SEQ_EN
  localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CW = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} lcd_state_t;

  lcd_state_t    state;
  logic [CW-1:0] cnt;
  logic          en_q;
  logic          busy_q;
  logic          ovf_q;

  // Stored bit 10 never reaches the pin or the readback here.
  logic unused_lcd_bit;
  assign unused_lcd_bit = lcd_q[10];

  // The counter is loaded with (phase length - 1) on every state entry and
  // the phase ends on the edge that sees it at zero. EN and busy are kept
  // as flops that change together with the state, so the pins are glitch
  // free and clear asynchronously with reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      cnt    <= '0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
      lcd_q  <= '0;
    end else begin
      if (wr_lcd && state != IDLE) ovf_q <= 1'b1;
      case (state)
        IDLE: begin
          if (wr_lcd) begin
            lcd_q <= store_val;
            if (i_bmask[0]) begin
              ovf_q  <= 1'b0;
              state  <= SETUP;
              cnt    <= CW'(SETUP_CYC - 1);
              busy_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= PULSE;
            cnt   <= CW'(PULSE_CYC - 1);
            en_q  <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            state <= HOLD;
            cnt   <= CW'(HOLD_CYC - 1);
            en_q  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_io_lcd   = {lcd_q[31:11], en_q, lcd_q[9:0]};
  assign o_lcd_busy = busy_q;
  assign lcd_rd     = {lcd_q[31], busy_q, ovf_q, lcd_q[28:11], 1'b0, lcd_q[9:0]};
`else
  // Without the sequencer every LCD store is accepted and the register,
  // including the EN bit, goes straight to the pins.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) lcd_q <= '0;
    else if (wr_lcd) lcd_q <= store_val;
  end

  assign o_io_lcd   = lcd_q;
  assign o_lcd_busy = 1'b0;
  assign lcd_rd     = lcd_q;
`endif

  // Readback is purely combinational and ignores the store strobe, so a
  // load in the same cycle as a store sees the pre-store value.
  always_comb begin
    o_ld_data = '0;
    if (hit) begin
      case (sel)
        SEL_LEDR:  o_ld_data = ledr_q;
        SEL_LEDG:  o_ld_data = ledg_q;
        SEL_HEXLO: o_ld_data = hexlo_q;
        SEL_HEXHI: o_ld_data = hexhi_q;
        SEL_LCD:   o_ld_data = lcd_rd;
        default:   o_ld_data = '0;
      endcase
    end
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_hex0 = hexlo_q[6:0];
  assign o_io_hex1 = hexlo_q[14:8];
  assign o_io_hex2 = hexlo_q[22:16];
  assign o_io_hex3 = hexlo_q[30:24];
  assign o_io_hex4 = hexhi_q[6:0];
  assign o_io_hex5 = hexhi_q[14:8];
  assign o_io_hex6 = hexhi_q[22:16];
  assign o_io_hex7 = hexhi_q[30:24];

endmodule

// File: tb/tb_output_buffer.sv
// -----------------------------------------------------------------------------
// tb_output_buffer
//
// Self-checking bench for output_buffer. A reference model keeps the register
// contents as plain words and describes the LCD sequencer as a timeline
// anchored at the edge that accepted the last LCD store. Follows the
// OUTPUT_BUFFER_LCD_SEQ_EN macro so the same file serves both builds.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_output_buffer;

  localparam logic [15:0] BASE = 16'h1000;
  localparam int S = 4;
  localparam int P = 25;
  localparam int H = 4;
`ifdef OUTPUT_BUFFER_LCD_SEQ_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        st_en;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic [3:0]  bmask;
  logic [31:0] ld_data, io_ledr, io_ledg, io_lcd;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic        lcd_busy;
  logic [55:0] hex_all;

  assign hex_all = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

  output_buffer #(
    .BASE_HI(BASE), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_st_en(st_en), .i_addr(addr),
    .i_st_data(st_data), .i_bmask(bmask), .o_ld_data(ld_data),
    .o_io_ledr(io_ledr), .o_io_ledg(io_ledg),
    .o_io_hex0(hex0), .o_io_hex1(hex1), .o_io_hex2(hex2), .o_io_hex3(hex3),
    .o_io_hex4(hex4), .o_io_hex5(hex5), .o_io_hex6(hex6), .o_io_hex7(hex7),
    .o_io_lcd(io_lcd), .o_lcd_busy(lcd_busy)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_reg [0:4];
  logic        m_ovf;
  int          m_k;

  task automatic m_reset();
    for (int i = 0; i < 5; i++) m_reg[i] = '0;
    m_ovf = 1'b0;
    m_k   = -1000;
  endtask

  // Sequencer state after edge c, from the edge k of the last accepted store.
  function automatic bit m_busy(input int c);
    return SEQ && (c >= m_k) && (c < m_k + S + P + H);
  endfunction

  function automatic bit m_en(input int c);
    return SEQ && (c >= m_k + S) && (c < m_k + S + P);
  endfunction

  function automatic logic [31:0] m_lcd_pin();
    logic [31:0] v;
    v = m_reg[4];
    if (SEQ) v[10] = m_en(cyc);
    return v;
  endfunction

  function automatic logic [55:0] m_hex();
    logic [31:0] lo, hi;
    lo = m_reg[2];
    hi = m_reg[3];
    return {hi[30:24], hi[22:16], hi[14:8], hi[6:0],
            lo[30:24], lo[22:16], lo[14:8], lo[6:0]};
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] r;
    int s;
    if (a[31:16] != BASE) return 32'h0;
    s = int'(a[14:12]);
    if (s > 4) return 32'h0;
    if (s == 4 && SEQ) begin
      r = m_reg[4];
      return {r[31], m_busy(cyc), m_ovf, r[28:11], 1'b0, r[9:0]};
    end
    return m_reg[s];
  endfunction

  // Applies a store to the model as of the upcoming edge cyc+1.
  task automatic m_store(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m);
    logic [31:0] v;
    int s;
    if (a[31:16] != BASE) return;
    s = int'(a[14:12]);
    if (s > 4) return;
    v = m_reg[s];
    for (int n = 0; n < 4; n++)
      if (m[n]) v[8*n +: 8] = d[8*n +: 8];
    if (s == 4 && SEQ) begin
      if (m_busy(cyc)) begin
        m_ovf = 1'b1;
        return;
      end
      m_reg[4] = v;
      if (m[0]) begin
        m_ovf = 1'b0;
        m_k   = cyc + 1;
      end
    end else begin
      m_reg[s] = v;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one store across one edge; readback in the store cycle must
  // still show the pre-store value.
  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    logic [31:0] exp;
    addr = a; st_data = d; bmask = m; st_en = 1'b1;
    #3;
    exp = m_read(a);
    checks++;
    if (ld_data !== exp) begin
      errors++;
      $display("[TB] FAIL same_cycle_rd addr=%h got %h want %h", a, ld_data, exp);
    end
    m_store(a, d, m);
    tick();
    st_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; st_en = 1'b0; addr = 32'h1000_4000; st_data = '0; bmask = '0;
    m_reset();
    #3;
    checks += 6;
    if (io_ledr !== 32'h0) begin errors++; $display("[TB] FAIL rst_ledr got %h want 0", io_ledr); end
    if (io_ledg !== 32'h0) begin errors++; $display("[TB] FAIL rst_ledg got %h want 0", io_ledg); end
    if (hex_all !== 56'h0) begin errors++; $display("[TB] FAIL rst_hex got %h want 0", hex_all); end
    if (io_lcd !== 32'h0) begin errors++; $display("[TB] FAIL rst_lcd got %h want 0", io_lcd); end
    if (lcd_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b want 0", lcd_busy); end
    if (ld_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_rd got %h want 0", ld_data); end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    store(32'h1000_0000, 32'hDEAD_BEEF, 4'b1111);
    addr = 32'h1000_0000;
    #1;
    checks += 2;
    if (io_ledr !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ledr_full got %h want deadbeef", io_ledr); end
    if (ld_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ledr_rd got %h want deadbeef", ld_data); end

    store(32'h1000_0000, 32'h1122_3344, 4'b0101);
    checks++;
    if (io_ledr !== 32'hDE22_BE44) begin errors++; $display("[TB] FAIL ledr_mask got %h want de22be44", io_ledr); end

    store(32'h1000_5000, 32'hFFFF_FFFF, 4'b1111);
    checks += 3;
    if (io_ledr !== 32'hDE22_BE44) begin errors++; $display("[TB] FAIL unmapped_ledr got %h want de22be44", io_ledr); end
    if (io_ledg !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_ledg got %h want 0", io_ledg); end
    if (ld_data !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_rd got %h want 0", ld_data); end

    store(32'h1000_2000, 32'h7F40_3F06, 4'b1111);
    checks += 5;
    if (hex0 !== 7'h06) begin errors++; $display("[TB] FAIL hex0 got %h want 06", hex0); end
    if (hex1 !== 7'h3F) begin errors++; $display("[TB] FAIL hex1 got %h want 3f", hex1); end
    if (hex2 !== 7'h40) begin errors++; $display("[TB] FAIL hex2 got %h want 40", hex2); end
    if (hex3 !== 7'h7F) begin errors++; $display("[TB] FAIL hex3 got %h want 7f", hex3); end
    if ({hex7, hex6, hex5, hex4} !== 28'h0) begin
      errors++; $display("[TB] FAIL hex_hi_zero got %h want 0", {hex7, hex6, hex5, hex4});
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, exp;
    logic [2:0]  s;
    logic [15:0] hi;
    int r, idle;
    for (int it = 0; it < 200; it++) begin
      r  = int'($urandom_range(0, 9));
      s  = 3'($urandom_range(0, 7));
      hi = BASE;
      if (r < 5) s = 3'(r);
      if (r == 9) hi = BASE ^ (16'h1 << $urandom_range(0, 15));
      a = {hi, 1'b0, s, 12'($urandom_range(0, 4095))};
      d = $urandom;
      store(a, d, 4'($urandom_range(0, 15)));
      checks += 6;
      if (io_ledr !== m_reg[0]) begin errors++; $display("[TB] FAIL rnd_ledr it=%0d got %h want %h", it, io_ledr, m_reg[0]); end
      if (io_ledg !== m_reg[1]) begin errors++; $display("[TB] FAIL rnd_ledg it=%0d got %h want %h", it, io_ledg, m_reg[1]); end
      if (hex_all !== m_hex()) begin errors++; $display("[TB] FAIL rnd_hex it=%0d got %h want %h", it, hex_all, m_hex()); end
      if (io_lcd !== m_lcd_pin()) begin errors++; $display("[TB] FAIL rnd_lcd it=%0d got %h want %h", it, io_lcd, m_lcd_pin()); end
      if (lcd_busy !== m_busy(cyc)) begin errors++; $display("[TB] FAIL rnd_busy it=%0d got %b want %b", it, lcd_busy, m_busy(cyc)); end
      exp = m_read(a);
      if (ld_data !== exp) begin errors++; $display("[TB] FAIL rnd_rd it=%0d addr=%h got %h want %h", it, a, ld_data, exp); end
      idle = int'($urandom_range(0, 3));
      for (int j = 0; j < idle; j++) begin
        addr = {BASE, 1'b0, 3'($urandom_range(0, 4)), 12'h0};
        tick();
        exp = m_read(addr);
        checks += 3;
        if (io_lcd !== m_lcd_pin()) begin errors++; $display("[TB] FAIL idle_lcd it=%0d got %h want %h", it, io_lcd, m_lcd_pin()); end
        if (lcd_busy !== m_busy(cyc)) begin errors++; $display("[TB] FAIL idle_busy it=%0d got %b want %b", it, lcd_busy, m_busy(cyc)); end
        if (ld_data !== exp) begin errors++; $display("[TB] FAIL idle_rd it=%0d addr=%h got %h want %h", it, addr, ld_data, exp); end
      end
    end
  endtask

`ifdef OUTPUT_BUFFER_LCD_SEQ_EN
  task automatic test_lcd_seq();
    int k, first_en, en_cnt, busy_cnt;
    while (m_busy(cyc)) tick();
    checks++;
    if (lcd_busy !== 1'b0) begin errors++; $display("[TB] FAIL seq_idle got %b want 0", lcd_busy); end
    store(32'h1000_4000, 32'h8000_0241, 4'b1111);
    k = cyc;
    first_en = -1; en_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      checks += 3;
      if (lcd_busy !== m_busy(cyc)) begin errors++; $display("[TB] FAIL seq_busy i=%0d got %b want %b", i, lcd_busy, m_busy(cyc)); end
      if (io_lcd[10] !== m_en(cyc)) begin errors++; $display("[TB] FAIL seq_en i=%0d got %b want %b", i, io_lcd[10], m_en(cyc)); end
      if ({io_lcd[31], io_lcd[9:0]} !== {1'b1, 10'h241}) begin
        errors++; $display("[TB] FAIL seq_pins i=%0d got %h want 8000241", i, io_lcd);
      end
      if (lcd_busy === 1'b1) busy_cnt++;
      if (io_lcd[10] === 1'b1) begin
        en_cnt++;
        if (first_en < 0) first_en = cyc;
      end
      if (i == 10) store(32'h1000_4000, 32'h0000_00FF, 4'b0001);
      else tick();
    end
    checks += 5;
    if (en_cnt != P) begin errors++; $display("[TB] FAIL seq_en_len got %0d want %0d", en_cnt, P); end
    if (busy_cnt != S + P + H) begin errors++; $display("[TB] FAIL seq_busy_len got %0d want %0d", busy_cnt, S + P + H); end
    if (first_en - k != S) begin errors++; $display("[TB] FAIL seq_en_start got %0d want %0d", first_en - k, S); end
    if (ld_data[29] !== 1'b1) begin errors++; $display("[TB] FAIL seq_ovf got %b want 1", ld_data[29]); end
    if (ld_data !== 32'hA000_0241) begin errors++; $display("[TB] FAIL seq_rd got %h want a0000241", ld_data); end
  endtask

  task automatic test_reset_mid_pulse();
    store(32'h1000_0000, 32'hA5A5_A5A5, 4'b1111);
    while (m_busy(cyc)) tick();
    store(32'h1000_4000, 32'h0000_0501, 4'b0001);
    for (int i = 0; i < S; i++) tick();
    checks++;
    if (io_lcd[10] !== 1'b1) begin errors++; $display("[TB] FAIL rmp_en_before got %b want 1", io_lcd[10]); end
    #2;
    reset = 1'b1;
    #1;
    m_reset();
    checks += 5;
    if (io_lcd !== 32'h0) begin errors++; $display("[TB] FAIL rmp_lcd got %h want 0", io_lcd); end
    if (lcd_busy !== 1'b0) begin errors++; $display("[TB] FAIL rmp_busy got %b want 0", lcd_busy); end
    if (io_ledr !== 32'h0) begin errors++; $display("[TB] FAIL rmp_ledr got %h want 0", io_ledr); end
    if (hex_all !== 56'h0) begin errors++; $display("[TB] FAIL rmp_hex got %h want 0", hex_all); end
    if (ld_data !== 32'h0) begin errors++; $display("[TB] FAIL rmp_rd got %h want 0", ld_data); end
    #2;
    reset = 1'b0;
    tick();
    store(32'h1000_4000, 32'h0000_0033, 4'b0001);
    checks += 2;
    if (lcd_busy !== 1'b1) begin errors++; $display("[TB] FAIL rmp_accept got %b want 1", lcd_busy); end
    if (io_lcd !== 32'h0000_0033) begin errors++; $display("[TB] FAIL rmp_lcd_after got %h want 33", io_lcd); end
  endtask
`else
  task automatic test_lcd_raw();
    store(32'h1000_4000, 32'h0000_0400, 4'b1111);
    addr = 32'h1000_4000;
    #1;
    checks += 3;
    if (io_lcd !== 32'h0000_0400) begin errors++; $display("[TB] FAIL raw_lcd got %h want 400", io_lcd); end
    if (lcd_busy !== 1'b0) begin errors++; $display("[TB] FAIL raw_busy got %b want 0", lcd_busy); end
    if (ld_data !== 32'h0000_0400) begin errors++; $display("[TB] FAIL raw_rd got %h want 400", ld_data); end
    store(32'h1000_4000, 32'h0000_0012, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 2;
      if (lcd_busy !== 1'b0) begin errors++; $display("[TB] FAIL raw_busy_idle got %b want 0", lcd_busy); end
      if (io_lcd !== 32'h0000_0412) begin errors++; $display("[TB] FAIL raw_lcd2 got %h want 412", io_lcd); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
`ifdef OUTPUT_BUFFER_LCD_SEQ_EN
    test_lcd_seq();
    test_reset_mid_pulse();
`else
    test_lcd_raw();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
